// File: rtl/logic_axi4_stream_credit_gate.sv
// Credit-gated AXI4-Stream pass-through. Credits arrive on credit_rx, and each beat or packet spends one.
// Define LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN to drive tx from a 2-entry skid buffer.
module logic_axi4_stream_credit_gate #(
  parameter int CREDIT_MAX   = 256,
  parameter int CREDIT_WIDTH = $clog2(CREDIT_MAX + 1),
  parameter int PACKETS      = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int USER_WIDTH   = 1,
  parameter int DEST_WIDTH   = 1,
  parameter int ID_WIDTH     = 1,
  localparam int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  // credit grants
  input  logic                    credit_rx_tvalid,
  output logic                    credit_rx_tready,
  input  logic [CREDIT_WIDTH-1:0] credit_rx_tdata,
  // gated data input
  input  logic                    rx_tvalid,
  output logic                    rx_tready,
  input  logic [DATA_WIDTH-1:0]   rx_tdata,
  input  logic                    rx_tlast,
  input  logic [KEEP_WIDTH-1:0]   rx_tstrb,
  input  logic [KEEP_WIDTH-1:0]   rx_tkeep,
  input  logic [USER_WIDTH-1:0]   rx_tuser,
  input  logic [DEST_WIDTH-1:0]   rx_tdest,
  input  logic [ID_WIDTH-1:0]     rx_tid,
  // gated data output
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [DATA_WIDTH-1:0]   tx_tdata,
  output logic                    tx_tlast,
  output logic [KEEP_WIDTH-1:0]   tx_tstrb,
  output logic [KEEP_WIDTH-1:0]   tx_tkeep,
  output logic [USER_WIDTH-1:0]   tx_tuser,
  output logic [DEST_WIDTH-1:0]   tx_tdest,
  output logic [ID_WIDTH-1:0]     tx_tid,
  output logic [CREDIT_WIDTH-1:0] credit
);

  localparam logic [CREDIT_WIDTH-1:0] LP_MAX     = CREDIT_WIDTH'(CREDIT_MAX);
  localparam logic [CREDIT_WIDTH:0]   LP_MAX_EXT = (CREDIT_WIDTH + 1)'(CREDIT_MAX);

  logic [CREDIT_WIDTH-1:0] r_credit;
  logic [CREDIT_WIDTH:0]   w_sum;
  logic [CREDIT_WIDTH-1:0] w_credit_next;
  logic                    w_credit_nz;
  logic                    w_credit_acc;
  logic                    w_rx_hs;
  logic                    w_consume;

  assign w_credit_nz      = (r_credit != '0);
  assign credit_rx_tready = (r_credit < LP_MAX);
  assign w_credit_acc     = credit_rx_tvalid && credit_rx_tready;
  assign w_rx_hs          = rx_tvalid && rx_tready;
  // In packet mode only the tlast beat spends a credit, so a started packet always completes.
  assign w_consume        = (PACKETS == 0) ? w_rx_hs : (w_rx_hs && rx_tlast);
  assign credit           = r_credit;

  // One extra bit holds credit + amount before the clamp, so no grant is lost to wrap.
  always_comb begin
    // NOTE: blocking assignments here build one combinational chain; defaults first keep it latch-free.
    w_sum = {1'b0, r_credit};
    if (w_credit_acc) w_sum = w_sum + {1'b0, credit_rx_tdata};
    if (w_consume)    w_sum = w_sum - (CREDIT_WIDTH + 1)'(1);
    w_credit_next = (w_sum > LP_MAX_EXT) ? LP_MAX : w_sum[CREDIT_WIDTH-1:0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_credit <= '0;
    else        r_credit <= w_credit_next;
  end

`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + 1 + 2 * KEEP_WIDTH + USER_WIDTH + DEST_WIDTH + ID_WIDTH;

  logic [PAYLOAD_WIDTH-1:0] r_mem [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_count;
  logic [PAYLOAD_WIDTH-1:0] w_rx_payload;
  logic                     w_push;
  logic                     w_pop;

  assign w_rx_payload = {rx_tdata, rx_tlast, rx_tstrb, rx_tkeep, rx_tuser, rx_tdest, rx_tid};
  assign rx_tready    = (r_count != 2'd2) && w_credit_nz;
  assign tx_tvalid    = (r_count != 2'd0);
  assign w_push       = w_rx_hs;
  assign w_pop        = tx_tvalid && tx_tready;
  assign {tx_tdata, tx_tlast, tx_tstrb, tx_tkeep, tx_tuser, tx_tdest, tx_tid} = r_mem[r_rd_ptr];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; r_count alone says which entries are valid.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rx_payload;
  end
`else
  assign tx_tvalid = rx_tvalid && w_credit_nz;
  assign rx_tready = tx_tready && w_credit_nz;
  assign tx_tdata  = rx_tdata;
  assign tx_tlast  = rx_tlast;
  assign tx_tstrb  = rx_tstrb;
  assign tx_tkeep  = rx_tkeep;
  assign tx_tuser  = rx_tuser;
  assign tx_tdest  = rx_tdest;
  assign tx_tid    = rx_tid;
`endif

endmodule

// File: tb/tb_logic_axi4_stream_credit_gate.sv
// Bench for logic_axi4_stream_credit_gate: beat-mode (i0) and packet-mode (i1) instances share stimulus,
// and a queue/arithmetic model checks every cycle alongside directed literal checks.
module tb_logic_axi4_stream_credit_gate;

  localparam int CMAX  = 8;
  localparam int CW    = 4;
  localparam int DW    = 8;
  localparam int KW    = 1;
  localparam int UW    = 2;
  localparam int DESTW = 2;
  localparam int IDW   = 2;
  localparam int PW    = DW + 1 + 2 * KW + UW + DESTW + IDW;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          credit_rx_tvalid = 1'b0;
  logic [CW-1:0] credit_rx_tdata = '0;
  logic          rx_tvalid = 1'b0;
  logic [DW-1:0] rx_tdata = '0;
  logic          rx_tlast = 1'b0;
  logic [KW-1:0] rx_tstrb = '0;
  logic [KW-1:0] rx_tkeep = '0;
  logic [UW-1:0] rx_tuser = '0;
  logic [DESTW-1:0] rx_tdest = '0;
  logic [IDW-1:0]   rx_tid = '0;
  logic          tx_tready = 1'b1;

  logic [1:0]           d_credit_rx_tready, d_rx_tready, d_tx_tvalid, d_tx_tlast;
  logic [1:0][DW-1:0]   d_tx_tdata;
  logic [1:0][KW-1:0]   d_tx_tstrb, d_tx_tkeep;
  logic [1:0][UW-1:0]   d_tx_tuser;
  logic [1:0][DESTW-1:0] d_tx_tdest;
  logic [1:0][IDW-1:0]  d_tx_tid;
  logic [1:0][CW-1:0]   d_credit;
  logic [1:0][PW-1:0]   w_tx_pl;
  logic [PW-1:0]        w_rx_pl;

  int n_total = 0;
  int n_bad   = 0;
  int cyc_now = 0;
  int m_credit [2] = '{0, 0};
  int tx_cnt   [2] = '{0, 0};
  int streak   [2] = '{0, 0};
  int last_tx  [2] = '{-10, -10};

  always #5 aclk = ~aclk;

  assign w_rx_pl = {rx_tdata, rx_tlast, rx_tstrb, rx_tkeep, rx_tuser, rx_tdest, rx_tid};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign w_tx_pl[g] = {d_tx_tdata[g], d_tx_tlast[g], d_tx_tstrb[g], d_tx_tkeep[g],
                         d_tx_tuser[g], d_tx_tdest[g], d_tx_tid[g]};
    logic_axi4_stream_credit_gate #(
      .CREDIT_MAX(CMAX), .CREDIT_WIDTH(CW), .PACKETS(g), .DATA_WIDTH(DW),
      .USER_WIDTH(UW), .DEST_WIDTH(DESTW), .ID_WIDTH(IDW)
    ) u_dut (
      .aclk(aclk), .areset(areset),
      .credit_rx_tvalid(credit_rx_tvalid), .credit_rx_tready(d_credit_rx_tready[g]),
      .credit_rx_tdata(credit_rx_tdata),
      .rx_tvalid(rx_tvalid), .rx_tready(d_rx_tready[g]), .rx_tdata(rx_tdata), .rx_tlast(rx_tlast),
      .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser), .rx_tdest(rx_tdest), .rx_tid(rx_tid),
      .tx_tvalid(d_tx_tvalid[g]), .tx_tready(tx_tready), .tx_tdata(d_tx_tdata[g]), .tx_tlast(d_tx_tlast[g]),
      .tx_tstrb(d_tx_tstrb[g]), .tx_tkeep(d_tx_tkeep[g]), .tx_tuser(d_tx_tuser[g]),
      .tx_tdest(d_tx_tdest[g]), .tx_tid(d_tx_tid[g]),
      .credit(d_credit[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
  // Beats accepted by each instance but not yet delivered, oldest first.
  logic [PW-1:0] q0 [$];
  logic [PW-1:0] q1 [$];
  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic logic [PW-1:0] q_front(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction
  function automatic void q_pop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction
  function automatic void q_push(input int k, input logic [PW-1:0] x);
    if (k == 0) q0.push_back(x); else q1.push_back(x);
  endfunction
  function automatic void q_clear();
    q0.delete();
    q1.delete();
  endfunction
`endif

  // Model and per-cycle compare; m_credit holds the credit the DUT must show after the next edge.
  always @(negedge aclk) begin
    cyc_now = cyc_now + 1;
    for (int k = 0; k < 2; k++) begin : per_inst
      logic          exp_rrdy, exp_tv, acc, cons;
      logic [PW-1:0] exp_pl;
      int            nxt;
      if (areset) begin
        check($sformatf("i%0d_rst_credit", k), d_credit[k], 0);
        check($sformatf("i%0d_rst_crready", k), d_credit_rx_tready[k], 1);
        check($sformatf("i%0d_rst_rxready", k), d_rx_tready[k], 0);
        check($sformatf("i%0d_rst_txvalid", k), d_tx_tvalid[k], 0);
        m_credit[k] = 0;
      end else begin
`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
        exp_rrdy = (q_size(k) < 2) && (m_credit[k] != 0);
        exp_tv   = (q_size(k) != 0);
        exp_pl   = exp_tv ? q_front(k) : '0;
`else
        exp_rrdy = tx_tready && (m_credit[k] != 0);
        exp_tv   = rx_tvalid && (m_credit[k] != 0);
        exp_pl   = w_rx_pl;
`endif
        check($sformatf("i%0d_credit", k), d_credit[k], m_credit[k]);
        check($sformatf("i%0d_crready", k), d_credit_rx_tready[k], (m_credit[k] < CMAX) ? 1 : 0);
        check($sformatf("i%0d_rxready", k), d_rx_tready[k], exp_rrdy);
        check($sformatf("i%0d_txvalid", k), d_tx_tvalid[k], exp_tv);
        if (exp_tv) check($sformatf("i%0d_payload", k), w_tx_pl[k], exp_pl);
        if (d_tx_tvalid[k] && tx_tready) begin
          tx_cnt[k]++;
          streak[k]  = (last_tx[k] == cyc_now - 1) ? streak[k] + 1 : 1;
          last_tx[k] = cyc_now;
        end
        acc  = credit_rx_tvalid && (m_credit[k] < CMAX);
        cons = rx_tvalid && exp_rrdy && ((k == 0) || rx_tlast);
        nxt  = m_credit[k] + (acc ? int'(credit_rx_tdata) : 0) - (cons ? 1 : 0);
        m_credit[k] = (nxt > CMAX) ? CMAX : nxt;
`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
        if (exp_tv && tx_tready) q_pop(k);
        if (rx_tvalid && exp_rrdy) q_push(k, w_rx_pl);
`endif
      end
    end
`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
    if (areset) q_clear();
`endif
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input int idx, input int plen);
    rx_tdata = DW'(idx + 64);
    rx_tlast = ((idx + 1) % plen) == 0;
    rx_tstrb = 1'b1;
    rx_tkeep = 1'b1;
    rx_tuser = UW'(idx);
    rx_tdest = DESTW'(idx + 1);
    rx_tid   = IDW'(idx + 2);
  endtask

  task automatic do_reset();
    rx_tvalid        = 1'b0;
    credit_rx_tvalid = 1'b0;
    tx_tready        = 1'b1;
    areset           = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic grant(input int amt);
    credit_rx_tvalid = 1'b1;
    credit_rx_tdata  = CW'(amt);
    tick();
    credit_rx_tvalid = 1'b0;
  endtask

  // Offers n beats; advances only on a handshake with instance k; gives up after budget cycles.
  task automatic stream(input int k, input int n, input int plen, input int budget, input bit bp);
    int idx;
    int cyc;
    bit hs;
    idx = 0;
    cyc = 0;
    drive_beat(0, plen);
    rx_tvalid = 1'b1;
    while (idx < n && cyc < budget) begin
      if (bp) tx_tready = (cyc % 3) != 2;
      @(negedge aclk);
      hs = d_rx_tready[k];
      tick();
      cyc++;
      if (hs) begin
        idx++;
        if (idx < n) drive_beat(idx, plen);
      end
    end
    rx_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, s1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    tick();
    check("post_rst_crready", d_credit_rx_tready, 2'b11);
    check("post_rst_credit", d_credit, '0);
    check("post_rst_txvalid", d_tx_tvalid, 2'b00);

    // No credit: ten cycles of offered data, nothing passes.
    s0 = tx_cnt[0]; s1 = tx_cnt[1];
    drive_beat(0, 1);
    rx_tvalid = 1'b1;
    repeat (10) tick();
    rx_tvalid = 1'b0;
    check("nocred_beats_i0", tx_cnt[0] - s0, 0);
    check("nocred_beats_i1", tx_cnt[1] - s1, 0);
    check("nocred_credit", d_credit, '0);

    // Beat mode: grant 3, offer 5 -> 3 back-to-back beats.
    do_reset();
    grant(3);
    s0 = tx_cnt[0];
    stream(0, 5, 100, 12, 1'b0);
    repeat (3) tick();
    check("b2b_beats", tx_cnt[0] - s0, 3);
    check("b2b_streak", streak[0], 3);
    check("b2b_credit", d_credit[0], 0);
    check("b2b_rxready", d_rx_tready[0], 0);

    // Packet mode: grant 1, two 4-beat packets -> only the first passes.
    do_reset();
    grant(1);
    s0 = tx_cnt[0]; s1 = tx_cnt[1];
    stream(1, 8, 4, 20, 1'b0);
    repeat (4) tick();
    check("pkt_beats_i1", tx_cnt[1] - s1, 4);
    check("pkt_beats_i0", tx_cnt[0] - s0, 1);
    check("pkt_credit", d_credit, '0);

    // Saturation at CMAX, then one consume with a zero grant pending.
    do_reset();
    grant(6);
    grant(5);
    tick();
    check("sat_credit_i0", d_credit[0], 8);
    check("sat_credit_i1", d_credit[1], 8);
    check("sat_crready", d_credit_rx_tready, 2'b00);
    credit_rx_tvalid = 1'b1;
    credit_rx_tdata  = '0;
    drive_beat(0, 1);
    rx_tvalid = 1'b1;
    tick();
    rx_tvalid = 1'b0;
    tick();
    credit_rx_tvalid = 1'b0;
    check("unsat_credit_i0", d_credit[0], 7);
    check("unsat_credit_i1", d_credit[1], 7);
    check("unsat_crready", d_credit_rx_tready, 2'b11);

    // Oversized grant clamps.
    do_reset();
    grant(15);
    check("clamp_credit_i0", d_credit[0], 8);
    check("clamp_credit_i1", d_credit[1], 8);

    // Grant 2 and consume 1 in the same cycle from credit 1.
    do_reset();
    grant(1);
    credit_rx_tvalid = 1'b1;
    credit_rx_tdata  = CW'(2);
    drive_beat(0, 1);
    rx_tvalid = 1'b1;
    tick();
    credit_rx_tvalid = 1'b0;
    rx_tvalid = 1'b0;
    check("simul_credit_i0", d_credit[0], 2);
    check("simul_credit_i1", d_credit[1], 2);

    // Backpressure on tx while packets stream.
    do_reset();
    grant(8);
    s1 = tx_cnt[1];
    stream(1, 6, 3, 40, 1'b1);
    tx_tready = 1'b1;
    repeat (4) tick();
    check("bp_beats_i1", tx_cnt[1] - s1, 6);
    check("bp_credit_i1", d_credit[1], 6);

    // Reset while beats are in flight.
    do_reset();
    grant(4);
    tx_tready = 1'b0;
    drive_beat(0, 100);
    rx_tvalid = 1'b1;
    tick();
    drive_beat(1, 100);
    tick();
`ifdef LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN
    check("midrst_pre_txvalid", d_tx_tvalid, 2'b11);
    check("midrst_pre_credit_i0", d_credit[0], 2);
    check("midrst_pre_credit_i1", d_credit[1], 4);
`else
    check("midrst_pre_credit_i0", d_credit[0], 4);
    check("midrst_pre_credit_i1", d_credit[1], 4);
`endif
    #2 areset = 1'b1;
    #1;
    check("midrst_txvalid", d_tx_tvalid, 2'b00);
    check("midrst_credit", d_credit, '0);
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    s0 = tx_cnt[0]; s1 = tx_cnt[1];
    tick();
    areset = 1'b0;
    repeat (4) tick();
    check("midrst_after_i0", tx_cnt[0] - s0, 0);
    check("midrst_after_i1", tx_cnt[1] - s1, 0);
    check("midrst_crready", d_credit_rx_tready, 2'b11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_axi4_stream_credit_gate.md
LOGIC_AXI4_STREAM_CREDIT_GATE -- requirements
Module: logic_axi4_stream_credit_gate

Interface
REQ-001 Parameter CREDIT_MAX, default 256: SHALL set the maximum number of credits held (saturation value), minimum 1.
REQ-002 Parameter CREDIT_WIDTH, default $clog2(CREDIT_MAX + 1): SHALL set the credit counter width.
REQ-003 Parameter PACKETS, default 0: SHALL select the credit unit; 0 = one beat per credit, >0 = one packet (tlast-terminated) per credit.
REQ-004 Port aclk, input, 1, SHALL be the single clock; all logic on its rising edge.
REQ-005 Port areset, input, 1, SHALL be the reset, asynchronous and active-high.
REQ-006 Port credit_rx, input, AXI4-Stream rx modport: credit grants; tdata[CREDIT_WIDTH-1:0] is the credit amount; other sideband ignored.
REQ-007 Port rx, input, AXI4-Stream rx modport: gated data input.
REQ-008 Port tx, output, AXI4-Stream tx modport: gated data output; tdata, tlast, tstrb, tkeep, tuser, tdest, tid forwarded unchanged from rx.
REQ-009 Port credit, output, CREDIT_WIDTH: current credit counter value, registered.

Function
REQ-010 Credit counter SHALL hold 0..CREDIT_MAX; its register drives port credit.
REQ-011 credit_rx.tready SHALL be high when credit < CREDIT_MAX, low when credit == CREDIT_MAX.
REQ-012 Credit accept = credit_rx.tvalid && credit_rx.tready; the amount SHALL be added with saturation at CREDIT_MAX; amount 0 accepted without effect; amounts > CREDIT_MAX clamp.
REQ-013 Data pass SHALL be enabled only when credit != 0: tx.tvalid = rx.tvalid && (credit != 0), rx.tready = tx.tready && (credit != 0).
REQ-014 Consume event SHALL be rx.tvalid && rx.tready (PACKETS == 0), or rx.tvalid && rx.tready && rx.tlast (PACKETS > 0).
REQ-015 In packet mode, mid-packet beats SHALL pass while credit >= 1; credit decrements only on the tlast beat, so a started packet is never stalled by credit.
REQ-016 Simultaneous accept and consume in one cycle: credit_next = min(credit + amount - 1, CREDIT_MAX), computed with CREDIT_WIDTH+1 bits; no lost credit.
REQ-017 Credit updates SHALL take effect the cycle after the handshake (one-cycle latency from credit_rx handshake to rx.tready rising).
REQ-018 Counter SHALL never underflow or wrap; consume is impossible when credit == 0 by REQ-013.
REQ-019 Ready/valid rules: tx.tvalid, once high, SHALL stay high with stable payload until tx.tready (guaranteed since credit cannot drop without a handshake).

Reset
REQ-020 On areset high: credit = 0, tx.tvalid = 0, rx.tready = 0, credit_rx.tready = 1 after reset release (CREDIT_MAX >= 1).
REQ-021 Reset mid-packet or mid-transfer SHALL discard all credit and any buffered beat; no partial beat emitted after release.

Configuration
REQ-022 Macro LOGIC_AXI4_STREAM_CREDIT_GATE_REGISTERED_EN defined: tx SHALL be driven from a 2-entry skid buffer; rx.tready = buffer-not-full && credit != 0; one cycle added rx->tx latency; credit consumed at rx handshake; full throughput sustained.
REQ-023 Macro undefined: tx SHALL be the combinational pass-through of REQ-013, zero latency, no storage.

Verification
REQ-024 After reset, rx.tvalid=1 for 10 cycles, no credit -> tx.tvalid stays 0, credit = 0, no beats pass.
REQ-025 PACKETS=0, grant 3, rx streams 5 beats with tx.tready=1 -> exactly 3 beats pass back-to-back, credit 3->0, rx.tready low afterward.
REQ-026 PACKETS=1, grant 1, two 4-beat packets -> first packet passes fully (credit stays 1 until its tlast), second blocked; credit 0.
REQ-027 CREDIT_MAX=8, credit 6, grant 5 -> credit saturates to 8, credit_rx.tready low; then one consume with grant 0 pending -> credit 7, tready high.
REQ-028 Credit 1, in one cycle grant 2 and consume 1 beat -> credit = 2 next cycle.
REQ-029 Assert areset mid-packet with credit 4 and skid buffer holding 2 beats (REGISTERED_EN) -> credit 0, tx.tvalid 0, buffer empty after release.
